// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int IMEM_AW = 12;
  localparam int INSTR_W = 32;
  localparam logic [IMEM_AW-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HOLD} fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] inst;
    logic [IMEM_AW-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst,pc} holding register used when decode stalls the output register.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_pop,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);
  logic         r_valid;
  fetch_entry_t r_entry;

  // load wins over pop: a move-out and refill in one cycle keeps the entry live
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, one-cycle imem latency, output register plus skid entry.
module fetch_stage
  import fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  output logic [IMEM_AW-1:0] address_imem,
  input  logic [INSTR_W-1:0] q_imem,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [IMEM_AW-1:0] redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst,
  output logic [IMEM_AW-1:0] inst_pc,
  output logic [IMEM_AW-1:0] inst_pc_plus1
);
  fetch_state_e       r_state, w_state_nxt;
  logic [IMEM_AW-1:0] r_pc;
  logic               r_pending;
  logic [IMEM_AW-1:0] r_pend_pc;
  logic               r_out_valid;
  fetch_entry_t       r_out;

  logic               w_redir, w_deq, w_out_free, w_ret, w_issue;
  logic [1:0]         w_occ;
  logic               w_skid_valid, w_skid_load, w_skid_pop;
  fetch_entry_t       w_skid_entry, w_ret_entry;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_BOOT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = fetch_en ? ST_RUN : ST_HOLD;
      ST_RUN:  if (!fetch_en) w_state_nxt = ST_HOLD;
      ST_HOLD: if (fetch_en)  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  assign w_redir      = redirect && (r_state != ST_BOOT);
  assign address_imem = redirect ? redirect_pc : r_pc;
  assign w_deq        = r_out_valid & inst_ready;
  assign w_out_free   = ~r_out_valid | w_deq;

  // occupancy counted after this cycle's dequeue; capped at 2 so a return always has a slot
  assign w_occ   = {1'b0, r_out_valid & ~w_deq} + {1'b0, w_skid_valid} + {1'b0, r_pending};
  assign w_issue = w_redir | ((r_state == ST_RUN) && (w_occ < 2'd2));
  assign w_ret   = r_pending & ~w_redir;

  assign w_ret_entry = '{inst: q_imem, pc: r_pend_pc};
  assign w_skid_pop  = w_out_free & w_skid_valid;
  assign w_skid_load = w_ret & (~w_out_free | w_skid_valid);

  fetch_skid_buf u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (w_redir),
    .i_load  (w_skid_load),
    .i_pop   (w_skid_pop),
    .i_entry (w_ret_entry),
    .o_valid (w_skid_valid),
    .o_entry (w_skid_entry)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= RESET_PC;
      r_pending <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_pend_pc <= address_imem;
        r_pc      <= IMEM_AW'(address_imem + 1'b1);
      end
    end
  end

  // skid entry is older than any return, so it drains into the output first
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_redir) begin
      r_out_valid <= 1'b0;
    end else if (w_out_free) begin
      if (w_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out       <= w_skid_entry;
      end else if (w_ret) begin
        r_out_valid <= 1'b1;
        r_out       <= w_ret_entry;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign inst_valid    = r_out_valid;
  assign inst          = r_out.inst;
  assign inst_pc       = r_out.pc;
  assign inst_pc_plus1 = IMEM_AW'(r_out.pc + 1'b1);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem model returns word == address one cycle later.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] address_imem;
  logic [31:0] q_imem = '0;
  logic        fetch_en, redirect, inst_ready;
  logic [11:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [11:0] inst_pc, inst_pc_plus1;

  int          checks = 0;
  int          failures = 0;
  logic [11:0] exp_pc;

  fetch_stage dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address_imem  (address_imem),
    .q_imem        (q_imem),
    .fetch_en      (fetch_en),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_pc_plus1 (inst_pc_plus1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) q_imem <= {20'h0, address_imem};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    tick; tick;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 12'h0 ||
        inst_pc_plus1 !== 12'h1 || address_imem !== 12'h0) begin
      failures++;
      $display("FAIL reset_values: got v=%0b inst=%h pc=%h p1=%h addr=%h want 0/0/000/001/000",
               inst_valid, inst, inst_pc, inst_pc_plus1, address_imem);
    end
  endtask

  task automatic test_stream;
    fetch_en = 1'b1; inst_ready = 1'b1; reset_n = 1'b1;
    tick;
    checks++;
    if (inst_valid !== 1'b0 || address_imem !== 12'h000) begin
      failures++;
      $display("FAIL stream_boot: got v=%0b addr=%h want 0/000", inst_valid, address_imem);
    end
    tick;
    checks++;
    if (inst_valid !== 1'b0 || address_imem !== 12'h001) begin
      failures++;
      $display("FAIL stream_lat: got v=%0b addr=%h want 0/001", inst_valid, address_imem);
    end
    tick;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 12'h000 || inst !== 32'h0) begin
      failures++;
      $display("FAIL stream_first: got v=%0b pc=%h inst=%h want 1/000/0", inst_valid, inst_pc, inst);
    end
    exp_pc = 12'h001;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== {20'h0, exp_pc} ||
          inst_pc_plus1 !== 12'(exp_pc + 1)) begin
        failures++;
        $display("FAIL stream_seq: got v=%0b pc=%h inst=%h p1=%h want pc=%h",
                 inst_valid, inst_pc, inst, inst_pc_plus1, exp_pc);
      end
      exp_pc++;
    end
  endtask

  task automatic test_redirect;
    inst_ready = 1'b0;
    tick;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 12'h005) begin
      failures++;
      $display("FAIL redir_setup: got v=%0b pc=%h want 1/005", inst_valid, inst_pc);
    end
    redirect = 1'b1; redirect_pc = 12'h080;
    #1;
    checks++;
    if (address_imem !== 12'h080) begin
      failures++;
      $display("FAIL redir_addr: got %h want 080", address_imem);
    end
    tick;
    redirect = 1'b0; inst_ready = 1'b1;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_flush: got v=%0b pc=%h want v=0", inst_valid, inst_pc);
    end
    exp_pc = 12'h080;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== {20'h0, exp_pc}) begin
        failures++;
        $display("FAIL redir_seq: got v=%0b pc=%h inst=%h want pc=%h", inst_valid, inst_pc, inst, exp_pc);
      end
      exp_pc++;
    end
  endtask

  task automatic test_stall;
    logic [11:0] held;
    held = 12'(exp_pc - 1);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== held || inst !== {20'h0, held} ||
          address_imem !== 12'(held + 2)) begin
        failures++;
        $display("FAIL stall_hold: got v=%0b pc=%h inst=%h addr=%h want pc=%h addr=%h",
                 inst_valid, inst_pc, inst, address_imem, held, 12'(held + 2));
      end
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin
        failures++;
        $display("FAIL stall_resume: got v=%0b pc=%h want pc=%h", inst_valid, inst_pc, exp_pc);
      end
      exp_pc++;
    end
  endtask

  task automatic test_wrap;
    redirect = 1'b1; redirect_pc = 12'hFFE;
    tick;
    redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_flush: got v=%0b want 0", inst_valid);
    end
    exp_pc = 12'hFFE;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_pc_plus1 !== 12'(exp_pc + 1)) begin
        failures++;
        $display("FAIL wrap_seq: got v=%0b pc=%h p1=%h want pc=%h p1=%h",
                 inst_valid, inst_pc, inst_pc_plus1, exp_pc, 12'(exp_pc + 1));
      end
      exp_pc++;
    end
  endtask

  task automatic test_fetch_en;
    int delivered;
    bit seen;
    delivered = 0;
    fetch_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (inst_valid === 1'b1) begin
        checks++;
        if (inst_pc !== exp_pc) begin
          failures++;
          $display("FAIL fen_drain: got pc=%h want %h", inst_pc, exp_pc);
        end
        exp_pc++;
        delivered++;
      end
    end
    checks++;
    if (delivered < 1 || delivered > 2 || inst_valid !== 1'b0 || address_imem !== exp_pc) begin
      failures++;
      $display("FAIL fen_idle: got delivered=%0d v=%0b addr=%h want 1..2/0/%h",
               delivered, inst_valid, address_imem, exp_pc);
    end
    fetch_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      if (inst_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || inst_pc !== exp_pc) begin
      failures++;
      $display("FAIL fen_resume: got seen=%0b pc=%h want 1/%h", seen, inst_pc, exp_pc);
    end
  endtask

  task automatic test_reset_inflight;
    bit seen;
    tick;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 12'h0 ||
        inst_pc_plus1 !== 12'h1 || address_imem !== 12'h0) begin
      failures++;
      $display("FAIL rst_async: got v=%0b inst=%h pc=%h p1=%h addr=%h want 0/0/000/001/000",
               inst_valid, inst, inst_pc, inst_pc_plus1, address_imem);
    end
    tick; tick;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      if (inst_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || inst_pc !== 12'h000 || inst !== 32'h0) begin
      failures++;
      $display("FAIL rst_restart: got seen=%0b pc=%h inst=%h want 1/000/0", seen, inst_pc, inst);
    end
    tick;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 12'h001) begin
      failures++;
      $display("FAIL rst_next: got v=%0b pc=%h want 1/001", inst_valid, inst_pc);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_redirect;
    test_stall;
    test_wrap;
    test_fetch_en;
    test_reset_inflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset_n  in  1  asynchronous active-low reset; deassertion is synchronous to clock.
REQ-003 address_imem  out  12  instruction memory word address; combinational.
REQ-004 q_imem  in  32  instruction memory data; valid one cycle after its address is presented.
REQ-005 fetch_en  in  1  high = issue fetches; low = hold PC, no new issues.
REQ-006 redirect  in  1  branch/jump taken; flushes fetch.
REQ-007 redirect_pc  in  12  target word address, sampled when redirect=1.
REQ-008 inst_valid  out  1  inst/inst_pc hold a live instruction for decode.
REQ-009 inst_ready  in  1  decode accepts; transfer when inst_valid & inst_ready.
REQ-010 inst  out  32  instruction word feeding the control decoder (opcode in [31:27]).
REQ-011 inst_pc  out  12  word address of inst.
REQ-012 inst_pc_plus1  out  12  inst_pc+1 mod 4096, for link/branch math.

Function
REQ-013 FSM states: BOOT, RUN, HOLD.
- BOOT: first cycle after reset release; no issue; goes to RUN if fetch_en, else HOLD.
- RUN -> HOLD when fetch_en=0.
- HOLD -> RUN when fetch_en=1.
- redirect is honoured in RUN and HOLD.
REQ-014 Fetch address: address_imem = redirect ? redirect_pc : pc.
REQ-015 Issue condition, evaluated per cycle: state==RUN or redirect, and occupancy after this cycle's dequeue is < 2.
- occupancy = out_valid + skid_valid + pending.
- An issue sets pending for the next cycle and loads pc <= address_imem+1 (mod 4096, 4095 wraps to 0).
REQ-016 Return: when pending=1, the q_imem word and its PC are written to the output register if it is empty or being dequeued; otherwise they are written to the one-entry skid buffer.
REQ-017 Ordering: when the output register frees, the skid entry moves to the output before any new return; order is strictly program order.
REQ-018 Throughput: in RUN, with inst_ready held high and no redirect, one instruction per cycle is delivered after a 2-cycle initial latency (BOOT plus memory latency).
REQ-019 Redirect cycle:
- clear out_valid, skid_valid and the current return; the return arriving that cycle is discarded.
- issue redirect_pc in the same cycle.
- the first target instruction is valid 1 cycle later.
REQ-020 Redirect with a simultaneous inst_ready counts as a completed transfer of the current inst; redirect dominates all other updates.
REQ-021 fetch_en low: in-flight pending returns still land; held instructions remain valid until consumed.
REQ-022 inst, inst_pc and inst_pc_plus1 are stable while inst_valid=1 and inst_ready=0.
REQ-023 No combinational path from inst_ready to inst_valid.

Reset
REQ-024 On reset_n=0, regardless of state or traffic in flight:
- state=BOOT; pc=0.
- pending=0, skid_valid=0, inst_valid=0.
- inst=0, inst_pc=0, inst_pc_plus1=1.
- address_imem=0.
REQ-025 A return that was pending when reset asserted is never delivered.

Structure
REQ-026 Shared package fetch_pkg holds:
- IMEM_AW=12, INSTR_W=32, RESET_PC=0.
- the FSM state enum.
REQ-027 One sub-module, fetch_skid_buf: 1-entry {inst,pc} holding register with valid flag; all other logic is in fetch_stage.

Verification
REQ-028 The bench covers these directed scenarios:
- Reset release, fetch_en=1, inst_ready=1, memory returns word=addr -> address_imem 0,1,2...; inst_valid first high 2 cycles after release with inst_pc=0; one instruction per cycle thereafter.
- Stall: inst_ready=0 for 5 cycles during streaming -> at most 2 instructions buffered; issues stop; after release inst_pc is continuous with no duplicates or gaps.
- Redirect to 0x080 while inst_pc=0x005 and skid full -> next inst_valid carries inst_pc=0x080 one cycle later; 0x006/0x007 are never presented.
- Wrap: pc=0xFFF -> inst_pc 0xFFF, then 0x000; inst_pc_plus1 for 0xFFF is 0x000.
- fetch_en dropped mid-stream -> pending word delivered, then no issues; re-enable resumes at the next sequential PC.
- reset_n pulsed low with pending=1 and inst_valid=1 -> outputs at reset values immediately; the stale word is never delivered; restart from PC 0.
